multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM that sequences a shared-resource multicycle MIPS datapath: one memory for instructions and data, one ALU for PC increment, branch target and execution. Takes opcode/funct from the instruction register plus the ALU `zero` flag, and drives every mux select, write enable and ALU code in the datapath. All control outputs are Moore outputs decoded from the state register; only `pcen` also depends on `zero`.

## Interface
Parameters: none.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; forces state to FETCH
- `op`  in  6  instr[31:26] from instruction register
- `funct`  in  6  instr[5:0] from instruction register
- `zero`  in  1  ALU result == 0
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memwrite`  out  1  memory write enable
- `irwrite`  out  1  instruction register load
- `regdst`  out  1  destination: 0 = rt, 1 = rd
- `memtoreg`  out  1  writeback: 0 = ALUOut, 1 = data register
- `regwrite`  out  1  register file write enable
- `alusrca`  out  1  ALU A: 0 = PC, 1 = register A
- `alusrcb`  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = imm ext, 11 = imm ext<<2
- `zeroext`  out  1  immediate extension: 0 = sign, 1 = zero
- `pcsrc`  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `pcen`  out  1  PC load = pcwrite | (branch & zero)
- `alucontrol`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, ori 001101.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEX (addi), JUMP (j), ORIEX (ori, only with the macro).
  - Any other opcode in DECODE→FETCH. The instruction is treated as a nop with no register or memory write.
  - MEMADR→MEMRD (lw) or MEMWR (sw). MEMRD→MEMWB→FETCH. MEMWR→FETCH.
  - EXECUTE→ALUWB→FETCH. ADDIEX→ADDIWB→FETCH. ORIEX→ORIWB→FETCH. BRANCH→FETCH. JUMP→FETCH.
- State outputs (any output not listed is 0; alucontrol defaults to 010):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, add.
  - DECODE: alusrcb=11, add (branch target into ALUOut).
  - MEMADR / ADDIEX: alusrca=1, alusrcb=10, add.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, funct-decoded ALU code.
  - ALUWB: regdst=1, regwrite=1.
  - ADDIWB / ORIWB: regwrite=1.
  - BRANCH: alusrca=1, sub, pcsrc=01, branch=1.
  - JUMP: pcsrc=10, pcwrite=1.
  - ORIEX: alusrca=1, alusrcb=10, zeroext=1, or.
- funct decode in EXECUTE:
  - 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Any other funct→010. The write still occurs.
- `op`/`funct` are sampled only in DECODE, MEMADR and EXECUTE. The instruction register holds them stable, and the controller does not latch them.

## Timing
- State register updates on posedge clk. All outputs are combinational from state; `pcen` is also combinational from `zero` in BRANCH.
- Reset is asynchronous and takes effect immediately. While reset is high, outputs show the FETCH decode: irwrite=1, pcen=1, alusrcb=01, alucontrol=010, all others 0.
- The first fetch completes on the first clock edge after reset deasserts.
- Cycles per instruction, counting FETCH: lw 5, sw 4, R 4, addi 4, ori 4, beq 3, j 3, unknown opcode 2.
- Reset asserted mid-instruction abandons it and forces FETCH on the same cycle. No partial writes occur after assertion, because the FETCH decode has regwrite=0 and memwrite=0.
- BRANCH with zero=0 gives pcen=0; the PC keeps PC+4 from FETCH.

## Configuration
- `MC_CTRL_ORI_EN` defined: ORIEX/ORIWB states exist and op 001101 executes ori with a zero-extended immediate.
- Not defined: those states are absent, op 001101 takes the unknown-opcode path, and `zeroext` is tied to 0. The port list is identical in both builds.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_ORI);
  - funct localparams;
  - ALU code localparams;
  - alusrcb/pcsrc encodings.
- Sub-module `alu_decoder` maps funct to `alucontrol` and is instantiated once. The FSM selects between its output and the fixed add/sub/or codes.

## Test plan
- Reset pulse mid-MEMWB, then release → same cycle state=FETCH and regwrite=0; next edge →DECODE; pcen=1 and irwrite=1 during reset.
- Apply op=100011 → state trace FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; memtoreg=1 and regwrite=1 only in MEMWB; iord=1 only in MEMRD.
- Apply op=000000, funct=101010 → alucontrol=111 in EXECUTE; regdst=1, regwrite=1 in ALUWB; 4-cycle instruction.
- Apply op=000100 with zero=1, then zero=0 → pcen=1, pcsrc=01 in BRANCH; then pcen=0; back to FETCH after 3 cycles.
- Apply op=000010, then op=111111 → JUMP asserts pcsrc=10, pcen=1; unknown opcode returns DECODE→FETCH with no regwrite/memwrite pulse.
- Apply op=001101 with the macro on → ORIEX gives zeroext=1, alucontrol=001, then ORIWB gives regwrite=1. With the macro off → 2-cycle nop and zeroext stays 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// MC_CTRL_ORI_EN adds the ORIEX/ORIWB states used by the ori instruction.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXECUTE,
      ALUWB,
      ADDIEX,
      ADDIWB,
      BRANCH,
      JUMP
`ifdef MC_CTRL_ORI_EN
      , ORIEX,
      ORIWB
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation code; unknown functs fall back to add.
module alu_decoder
   import mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (funct)
         FN_ADD:  alucontrol = ALU_ADD;
         FN_SUB:  alucontrol = ALU_SUB;
         FN_AND:  alucontrol = ALU_AND;
         FN_OR:   alucontrol = ALU_OR;
         FN_SLT:  alucontrol = ALU_SLT;
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath.
// MC_CTRL_ORI_EN enables ori (op 001101) with a zero-extended immediate.
module multicycle_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       zeroext,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [2:0] alucontrol
);

   // Current state, kept under a plain name so checkers can bind to it.
   state_t state, state_next;
   logic   pcwrite, branch;
   logic [2:0] funct_alu;

   alu_decoder u_alu_decoder (
      .funct      (funct),
      .alucontrol (funct_alu)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:   state_next = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = EXECUTE;
               OP_BEQ:       state_next = BRANCH;
               OP_ADDI:      state_next = ADDIEX;
               OP_J:         state_next = JUMP;
`ifdef MC_CTRL_ORI_EN
               OP_ORI:       state_next = ORIEX;
`endif
               default:      state_next = FETCH;
            endcase
         end
         MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_next = MEMWB;
         EXECUTE: state_next = ALUWB;
         ADDIEX:  state_next = ADDIWB;
`ifdef MC_CTRL_ORI_EN
         ORIEX:   state_next = ORIWB;
`endif
         default: state_next = FETCH;
      endcase
   end

   always_comb begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_REGB;
      zeroext    = 1'b0;
      pcsrc      = PCSRC_ALU;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      alucontrol = ALU_ADD;
      case (state)
         FETCH: begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            alusrcb = SRCB_FOUR;
         end
         // Branch target is computed early so BRANCH only needs the compare.
         DECODE:  alusrcb = SRCB_IMMSH;
         MEMADR, ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         EXECUTE: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_REGB;
            alucontrol = funct_alu;
         end
         ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         ADDIWB:  regwrite = 1'b1;
         BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = PCSRC_ALUOUT;
            branch     = 1'b1;
         end
         JUMP: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
         end
`ifdef MC_CTRL_ORI_EN
         ORIEX: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_IMM;
            zeroext    = 1'b1;
            alucontrol = ALU_OR;
         end
         ORIWB:   regwrite = 1'b1;
`endif
         default: ;
      endcase
   end

   assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle
// tables derived from the instruction set, directed cases then random mix.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic       zeroext, pcen;
   logic [2:0] alucontrol;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] exp_q[$];

`ifdef MC_CTRL_ORI_EN
   localparam bit ORI_EN = 1'b1;
`else
   localparam bit ORI_EN = 1'b0;
`endif

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
      .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc), .pcen(pcen),
      .alucontrol(alucontrol)
   );

   always #5 clk = ~clk;

   wire [15:0] ctrl = {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                       alusrca, alusrcb, zeroext, pcsrc, pcen, alucontrol};

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s op=%b funct=%b zero=%b got=%h expected=%h", tag, op, funct, zero, got, exp);
      end
   endtask

   function automatic logic [15:0] pack(input logic io, mw, irw, rd, m2r, rw, sa,
                                        input logic [1:0] sb, input logic ze,
                                        input logic [1:0] ps, input logic pe,
                                        input logic [2:0] ac);
      return {io, mw, irw, rd, m2r, rw, sa, sb, ze, ps, pe, ac};
   endfunction

   function automatic logic [15:0] fetch_ctrl();
      return pack(0, 0, 1, 0, 0, 0, 0, 2'b01, 0, 2'b00, 1, 3'b010);
   endfunction

   function automatic logic [2:0] funct_code(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic int cpi(input logic [5:0] o);
      case (o)
         6'b100011: return 5;
         6'b101011, 6'b000000, 6'b001000: return 4;
         6'b000100, 6'b000010: return 3;
         6'b001101: return ORI_EN ? 4 : 2;
         default:   return 2;
      endcase
   endfunction

   // Expected control word for cycle k (0 = fetch) of instruction o.
   function automatic logic [15:0] exp_ctrl(input logic [5:0] o, input logic [5:0] f,
                                            input logic z, input int k);
      if (k == 0) return fetch_ctrl();
      if (k == 1) return pack(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 0, 3'b010);
      case (o)
         6'b100011, 6'b101011: begin
            if (k == 2) return pack(0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 3'b010);
            if (o == 6'b101011) return pack(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b010);
            if (k == 3) return pack(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b010);
            return pack(0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 0, 3'b010);
         end
         6'b000000: begin
            if (k == 2) return pack(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, funct_code(f));
            return pack(0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0, 3'b010);
         end
         6'b001000: begin
            if (k == 2) return pack(0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 3'b010);
            return pack(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 3'b010);
         end
         6'b001101: begin
            if (k == 2) return pack(0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 0, 3'b001);
            return pack(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 3'b010);
         end
         6'b000100: return pack(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, z, 3'b110);
         6'b000010: return pack(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 1, 3'b010);
         default:   return 16'hxxxx;
      endcase
   endfunction

   // Called at a negedge while the DUT is in FETCH; returns at the next FETCH.
   // zsel < 0 randomises zero every cycle; abort_k >= 0 pulses reset in that cycle.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input int zsel, input int abort_k);
      int n;
      n = cpi(o);
      for (int k = 0; k < n; k++) begin
         op    = o;
         funct = f;
         zero  = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
         exp_q.push_back(exp_ctrl(o, f, zero, k));
         #1;
         check_eq($sformatf("cyc%0d", k), ctrl, exp_q.pop_front());
         if (k == abort_k) begin
            #1 reset = 1'b1;
            #1 check_eq("rst_async", ctrl, fetch_ctrl());
            @(negedge clk);
            check_eq("rst_held", ctrl, fetch_ctrl());
            reset = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   logic [5:0] ops[8];
   logic [5:0] fns[6];
   logic [5:0] ro, rf;

   initial begin
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
              6'b001000, 6'b000010, 6'b001101, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
      reset = 1'b1;
      op    = 6'b0;
      funct = 6'b0;
      zero  = 1'b0;
      #1 check_eq("reset_t0", ctrl, fetch_ctrl());
      repeat (2) @(negedge clk);
      zero = 1'b1;
      #1 check_eq("reset_held", ctrl, fetch_ctrl());
      @(negedge clk);
      reset = 1'b0;

      run_instr(6'b100011, 6'b0, -1, 4);          // lw aborted in MEMWB
      run_instr(6'b100011, 6'b0, -1, -1);         // lw full
      run_instr(6'b000000, 6'b101010, -1, -1);    // slt
      run_instr(6'b000100, 6'b0, 1, -1);          // beq taken
      run_instr(6'b000100, 6'b0, 0, -1);          // beq not taken
      run_instr(6'b000010, 6'b0, -1, -1);         // j
      run_instr(6'b111111, 6'b0, -1, -1);         // unknown opcode
      run_instr(6'b001101, 6'h15, -1, -1);        // ori
      run_instr(6'b101011, 6'b0, -1, -1);         // sw
      run_instr(6'b001000, 6'b0, -1, -1);         // addi

      for (int i = 0; i < 200; i++) begin
         ro = ops[$urandom_range(0, 7)];
         if (ro == 6'b111111) ro = 6'($urandom_range(0, 63));
         rf = fns[$urandom_range(0, 5)];
         if (rf == 6'b000111) rf = 6'($urandom_range(0, 63));
         run_instr(ro, rf, -1, (i % 37 == 5) ? int'($urandom_range(0, 1)) : -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
